// File: rtl/axis_dm_pkg.sv
// ============================================================================
// Module   : axis_dm_pkg
// Brief    : DataMover command/status field map, FSM states, command packing.
// Revision : 1.0
// ============================================================================
`default_nettype none

package axis_dm_pkg;

    localparam int CMD_W        = 72;
    localparam int CMD_TAG_LSB  = 64;
    localparam int CMD_ADDR_LSB = 32;
    localparam int CMD_DRR_BIT  = 31;
    localparam int CMD_EOF_BIT  = 30;
    localparam int CMD_DSA_LSB  = 24;
    localparam int CMD_TYPE_BIT = 23;
    localparam int BTT_W        = 23;

    localparam int STS_OKAY_BIT   = 7;
    localparam int STS_SLVERR_BIT = 6;
    localparam int STS_DECERR_BIT = 5;
    localparam int STS_INTERR_BIT = 4;
    localparam int STS_TAG_W      = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_ERROR = 2'd3
    } state_t;

    // EOF set, INCR burst, no DRR / DSA realignment.
    function automatic logic [CMD_W-1:0] pack_cmd(
        input logic [3:0]       tag,
        input logic [31:0]      addr,
        input logic [BTT_W-1:0] btt
    );
        logic [CMD_W-1:0] c;
        c                              = '0;
        c[CMD_TAG_LSB +: 4]            = tag;
        c[CMD_ADDR_LSB +: 32]          = addr;
        c[CMD_DRR_BIT]                 = 1'b0;
        c[CMD_EOF_BIT]                 = 1'b1;
        c[CMD_DSA_LSB +: 6]            = 6'd0;
        c[CMD_TYPE_BIT]                = 1'b1;
        c[BTT_W-1:0]                   = btt;
        return c;
    endfunction

endpackage

`default_nettype wire

// File: rtl/axis_cmd_gen_s2mm.sv
// ============================================================================
// Module   : axis_cmd_gen_s2mm
// Brief    : Splits a capture region into DataMover S2MM write commands and
//            tracks returned status. Option macro: S2MM_TAG_CHECK_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module axis_cmd_gen_s2mm
    import axis_dm_pkg::*;
#(
    parameter int PACKET_SIZE     = 4096,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        write_start,
    input  logic        write_reset,
    input  logic        continuous,
    input  logic [31:0] base_addr,
    input  logic [31:0] cap_size,
    output logic [71:0] m_axis_cmd_tdata,
    output logic        m_axis_cmd_tvalid,
    input  logic        m_axis_cmd_tready,
    input  logic [7:0]  s_axis_sts_tdata,
    input  logic        s_axis_sts_tvalid,
    output logic        s_axis_sts_tready,
    output logic        busy,
    output logic        done,
    output logic        wr_err,
    output logic [31:0] current_addr,
    output logic [7:0]  run_cycles,
    output logic [7:0]  datamover_status
);

    localparam logic [31:0] PKT     = 32'(PACKET_SIZE);
    localparam logic [3:0]  MAX_OUT = 4'(MAX_OUTSTANDING);

    function automatic logic [BTT_W-1:0] btt_of(input logic [31:0] rem);
        return (rem < PKT) ? rem[BTT_W-1:0] : PKT[BTT_W-1:0];
    endfunction

    state_t      state_q, state_d;
    logic [31:0] base_q, base_d;
    logic [31:0] size_q, size_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] remaining_q, remaining_d;
    logic [3:0]  outstanding_q, outstanding_d;
    logic [3:0]  tag_q, tag_d;
    logic        wr_err_q, wr_err_d;
    logic [7:0]  run_cycles_q, run_cycles_d;
    logic [31:0] current_addr_q, current_addr_d;
    logic [7:0]  sts_q, sts_d;
    logic        tvalid_q, tvalid_d;
    logic [71:0] tdata_q, tdata_d;
    logic        done_q, done_d;
    logic [3:0]  exp_tag_q, exp_tag_d;

    logic             cmd_hs;
    logic             sts_acc;
    logic             sts_bad;
    logic             can_issue;
    logic [BTT_W-1:0] cur_btt;

`ifndef S2MM_TAG_CHECK_EN
    logic unused_sts_tag;
    assign unused_sts_tag = ^{s_axis_sts_tdata[STS_TAG_W-1:0], exp_tag_q};
`endif

    always_comb begin
        cmd_hs  = tvalid_q & m_axis_cmd_tready;
        // A status with nothing outstanding is stray and is ignored entirely.
        sts_acc = s_axis_sts_tvalid && (outstanding_q != 4'd0);
        sts_bad = sts_acc && (!s_axis_sts_tdata[STS_OKAY_BIT]
                              || s_axis_sts_tdata[STS_SLVERR_BIT]
                              || s_axis_sts_tdata[STS_DECERR_BIT]
                              || s_axis_sts_tdata[STS_INTERR_BIT]);
        exp_tag_d = exp_tag_q;
`ifdef S2MM_TAG_CHECK_EN
        if (sts_acc) begin
            exp_tag_d = exp_tag_q + 4'd1;
            if (s_axis_sts_tdata[STS_TAG_W-1:0] != exp_tag_q) begin
                sts_bad = 1'b1;
            end
        end
`endif
        cur_btt = btt_of(remaining_q);

        state_d        = state_q;
        base_d         = base_q;
        size_d         = size_q;
        addr_d         = addr_q;
        remaining_d    = remaining_q;
        outstanding_d  = outstanding_q;
        tag_d          = tag_q;
        wr_err_d       = wr_err_q | sts_bad;
        run_cycles_d   = run_cycles_q;
        current_addr_d = current_addr_q;
        sts_d          = sts_q;
        tvalid_d       = tvalid_q;
        tdata_d        = tdata_q;
        done_d         = 1'b0;

        case ({cmd_hs, sts_acc})
            2'b10:   outstanding_d = outstanding_q + 4'd1;
            2'b01:   outstanding_d = outstanding_q - 4'd1;
            default: outstanding_d = outstanding_q;
        endcase

        if (sts_acc) begin
            sts_d = s_axis_sts_tdata;
        end

        if (cmd_hs) begin
            tag_d          = tag_q + 4'd1;
            current_addr_d = addr_q;
            addr_d         = addr_q + {9'd0, cur_btt};
            remaining_d    = remaining_q - {9'd0, cur_btt};
        end

        can_issue = (outstanding_d < MAX_OUT) && !wr_err_d;

        case (state_q)
            ST_IDLE: begin
                if (write_start && (cap_size != 32'd0)) begin
                    base_d      = base_addr;
                    size_d      = cap_size;
                    addr_d      = base_addr;
                    remaining_d = cap_size;
                    tvalid_d    = 1'b1;
                    tdata_d     = pack_cmd(tag_q, base_addr, btt_of(cap_size));
                    state_d     = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (cmd_hs && (remaining_q == {9'd0, cur_btt})) begin
                    tvalid_d = 1'b0;
                    state_d  = wr_err_d ? ST_ERROR : ST_DRAIN;
                end else if (tvalid_q && !cmd_hs) begin
                    // Presented command stays put until accepted, even on error.
                    tvalid_d = 1'b1;
                end else if (can_issue) begin
                    tvalid_d = 1'b1;
                    tdata_d  = pack_cmd(tag_d, addr_d, btt_of(remaining_d));
                end else begin
                    tvalid_d = 1'b0;
                    if (wr_err_d) begin
                        state_d = ST_ERROR;
                    end
                end
            end
            ST_DRAIN: begin
                if (wr_err_d) begin
                    state_d = ST_ERROR;
                end else if (outstanding_d == 4'd0) begin
                    run_cycles_d = run_cycles_q + 8'd1;
                    if (continuous) begin
                        addr_d      = base_q;
                        remaining_d = size_q;
                        tvalid_d    = 1'b1;
                        tdata_d     = pack_cmd(tag_d, base_q, btt_of(size_q));
                        state_d     = ST_ISSUE;
                    end else begin
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_ERROR: begin
                tvalid_d = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (write_reset) begin
            state_d        = ST_IDLE;
            tvalid_d       = 1'b0;
            tdata_d        = '0;
            outstanding_d  = 4'd0;
            tag_d          = 4'd0;
            exp_tag_d      = 4'd0;
            wr_err_d       = 1'b0;
            run_cycles_d   = 8'd0;
            current_addr_d = 32'd0;
            sts_d          = 8'd0;
            done_d         = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            base_q         <= '0;
            size_q         <= '0;
            addr_q         <= '0;
            remaining_q    <= '0;
            outstanding_q  <= '0;
            tag_q          <= '0;
            exp_tag_q      <= '0;
            wr_err_q       <= 1'b0;
            run_cycles_q   <= '0;
            current_addr_q <= '0;
            sts_q          <= '0;
            tvalid_q       <= 1'b0;
            tdata_q        <= '0;
            done_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            base_q         <= base_d;
            size_q         <= size_d;
            addr_q         <= addr_d;
            remaining_q    <= remaining_d;
            outstanding_q  <= outstanding_d;
            tag_q          <= tag_d;
            exp_tag_q      <= exp_tag_d;
            wr_err_q       <= wr_err_d;
            run_cycles_q   <= run_cycles_d;
            current_addr_q <= current_addr_d;
            sts_q          <= sts_d;
            tvalid_q       <= tvalid_d;
            tdata_q        <= tdata_d;
            done_q         <= done_d;
        end
    end

    assign m_axis_cmd_tdata  = tdata_q;
    assign m_axis_cmd_tvalid = tvalid_q;
    assign s_axis_sts_tready = 1'b1;
    assign busy              = (state_q != ST_IDLE);
    assign done              = done_q;
    assign wr_err            = wr_err_q;
    assign current_addr      = current_addr_q;
    assign run_cycles        = run_cycles_q;
    assign datamover_status  = sts_q;

endmodule

`default_nettype wire

// File: tb/tb_axis_cmd_gen_s2mm.sv
// ============================================================================
// Module   : tb_axis_cmd_gen_s2mm
// Brief    : Directed self-checking bench for axis_cmd_gen_s2mm.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_axis_cmd_gen_s2mm;

    logic        clk = 1'b0;
    logic        rst;
    logic        write_start;
    logic        write_reset;
    logic        continuous;
    logic [31:0] base_addr;
    logic [31:0] cap_size;
    logic [71:0] m_axis_cmd_tdata;
    logic        m_axis_cmd_tvalid;
    logic        m_axis_cmd_tready;
    logic [7:0]  s_axis_sts_tdata;
    logic        s_axis_sts_tvalid;
    logic        s_axis_sts_tready;
    logic        busy;
    logic        done;
    logic        wr_err;
    logic [31:0] current_addr;
    logic [7:0]  run_cycles;
    logic [7:0]  datamover_status;

    axis_cmd_gen_s2mm #(.PACKET_SIZE(4096), .MAX_OUTSTANDING(4)) dut (
        .clk               (clk),
        .rst               (rst),
        .write_start       (write_start),
        .write_reset       (write_reset),
        .continuous        (continuous),
        .base_addr         (base_addr),
        .cap_size          (cap_size),
        .m_axis_cmd_tdata  (m_axis_cmd_tdata),
        .m_axis_cmd_tvalid (m_axis_cmd_tvalid),
        .m_axis_cmd_tready (m_axis_cmd_tready),
        .s_axis_sts_tdata  (s_axis_sts_tdata),
        .s_axis_sts_tvalid (s_axis_sts_tvalid),
        .s_axis_sts_tready (s_axis_sts_tready),
        .busy              (busy),
        .done              (done),
        .wr_err            (wr_err),
        .current_addr      (current_addr),
        .run_cycles        (run_cycles),
        .datamover_status  (datamover_status)
    );

    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_err = 0;
    logic [71:0] cmd_q[$];
    logic [7:0]  sts_fifo[$];
    logic        auto_sts = 1'b0;

    task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [71:0] mk(input logic [3:0] tag, input logic [31:0] a,
                                       input logic [22:0] btt);
        return {4'h0, tag, a, 8'h40, 1'b1, btt};
    endfunction

    // Command monitor and status responder; queued status goes out one per cycle.
    always @(negedge clk) begin
        logic hs;
        hs = m_axis_cmd_tvalid && m_axis_cmd_tready && !rst;
        if (hs) cmd_q.push_back(m_axis_cmd_tdata);
        if (sts_fifo.size() > 0) begin
            s_axis_sts_tvalid = 1'b1;
            s_axis_sts_tdata  = sts_fifo.pop_front();
        end else begin
            s_axis_sts_tvalid = 1'b0;
            s_axis_sts_tdata  = 8'h00;
        end
        if (auto_sts && hs) sts_fifo.push_back({4'h8, m_axis_cmd_tdata[67:64]});
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic soft_clear();
        auto_sts    = 1'b0;
        continuous  = 1'b0;
        m_axis_cmd_tready = 1'b0;
        write_reset = 1'b1;
        tick();
        write_reset = 1'b0;
        sts_fifo.delete();
        tick();
        cmd_q.delete();
    endtask

    task automatic start_run(input logic [31:0] b, input logic [31:0] c);
        base_addr   = b;
        cap_size    = c;
        write_start = 1'b1;
        tick();
        write_start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        chk(tag, {71'd0, seen}, 72'd1);
        tick();
        chk({tag, "_pulse_low"}, {71'd0, done}, 72'd0);
    endtask

    initial begin
        logic found;
        logic done_seen;
        rst = 1'b1; write_start = 1'b0; write_reset = 1'b0; continuous = 1'b0;
        base_addr = 32'd0; cap_size = 32'd0; m_axis_cmd_tready = 1'b0;
        s_axis_sts_tvalid = 1'b0; s_axis_sts_tdata = 8'h00;
        repeat (3) tick();
        rst = 1'b0;
        tick();

        chk("rst_tvalid", {71'd0, m_axis_cmd_tvalid}, 72'd0);
        chk("rst_tdata", m_axis_cmd_tdata, 72'd0);
        chk("rst_flags", {68'd0, busy, done, wr_err, s_axis_sts_tready}, 72'h1);
        chk("rst_regs", {32'd0, current_addr, run_cycles}, 72'd0);
        chk("rst_status", {64'd0, datamover_status}, 72'd0);

        // Zero-size start is ignored; write_reset wins over write_start.
        start_run(32'h1000_0000, 32'd0);
        chk("zero_cap_busy", {70'd0, busy, m_axis_cmd_tvalid}, 72'd0);
        write_reset = 1'b1;
        start_run(32'h1000_0000, 32'h1000);
        write_reset = 1'b0;
        chk("reset_prio_busy", {70'd0, busy, m_axis_cmd_tvalid}, 72'd0);

        // Three full packets.
        soft_clear();
        auto_sts = 1'b1; m_axis_cmd_tready = 1'b1;
        start_run(32'h1000_0000, 32'h3000);
        chk("t1_first_tvalid", {71'd0, m_axis_cmd_tvalid}, 72'd1);
        wait_done("t1_done");
        chk("t1_ncmd", cmd_q.size(), 3);
        chk("t1_cmd0", cmd_q[0], mk(4'd0, 32'h1000_0000, 23'h1000));
        chk("t1_cmd1", cmd_q[1], mk(4'd1, 32'h1000_1000, 23'h1000));
        chk("t1_cmd2", cmd_q[2], mk(4'd2, 32'h1000_2000, 23'h1000));
        chk("t1_runs", {64'd0, run_cycles}, 72'd1);
        chk("t1_busy", {71'd0, busy}, 72'd0);
        chk("t1_cur_addr", {40'd0, current_addr}, {40'd0, 32'h1000_2000});
        chk("t1_status", {64'd0, datamover_status}, 72'h82);

        // Short final packet.
        soft_clear();
        auto_sts = 1'b1; m_axis_cmd_tready = 1'b1;
        start_run(32'h2000_0000, 32'h2100);
        wait_done("t2_done");
        chk("t2_ncmd", cmd_q.size(), 3);
        chk("t2_cmd1", cmd_q[1], mk(4'd1, 32'h2000_1000, 23'h1000));
        chk("t2_cmd2", cmd_q[2], mk(4'd2, 32'h2000_2000, 23'h0100));
        chk("t2_runs", {64'd0, run_cycles}, 72'd1);

        // Outstanding limit.
        soft_clear();
        m_axis_cmd_tready = 1'b1;
        start_run(32'h5000_0000, 32'h8000);
        repeat (10) tick();
        chk("t3_ncmd_limit", cmd_q.size(), 4);
        chk("t3_tvalid_low", {70'd0, busy, m_axis_cmd_tvalid}, 72'h2);
        sts_fifo.push_back(8'h80);
        repeat (5) tick();
        chk("t3_ncmd_release", cmd_q.size(), 5);
        chk("t3_cmd4", cmd_q[4], mk(4'd4, 32'h5000_4000, 23'h1000));
        chk("t3_tvalid_low2", {71'd0, m_axis_cmd_tvalid}, 72'd0);
        chk("t3_status", {64'd0, datamover_status}, 72'h80);

        // SLVERR with a command pending.
        soft_clear();
        start_run(32'h3000_0000, 32'h4000);
        chk("t4_cmd0_tdata", m_axis_cmd_tdata, mk(4'd0, 32'h3000_0000, 23'h1000));
        m_axis_cmd_tready = 1'b1;
        tick();
        m_axis_cmd_tready = 1'b0;
        chk("t4_ncmd1", cmd_q.size(), 1);
        chk("t4_cmd1_tdata", m_axis_cmd_tdata, mk(4'd1, 32'h3000_1000, 23'h1000));
        sts_fifo.push_back(8'h41);
        tick();
        chk("t4_wr_err", {71'd0, wr_err}, 72'd1);
        chk("t4_pending_held", {71'd0, m_axis_cmd_tvalid}, 72'd1);
        m_axis_cmd_tready = 1'b1;
        tick();
        repeat (5) tick();
        chk("t4_ncmd_final", cmd_q.size(), 2);
        chk("t4_err_state", {69'd0, busy, wr_err, m_axis_cmd_tvalid}, 72'h6);
        chk("t4_status", {64'd0, datamover_status}, 72'h41);
        m_axis_cmd_tready = 1'b0;
        write_reset = 1'b1;
        tick();
        write_reset = 1'b0;
        chk("t4_cleared", {69'd0, busy, wr_err, m_axis_cmd_tvalid}, 72'd0);
        chk("t4_status_clr", {64'd0, datamover_status}, 72'd0);

        // Continuous mode, then write_reset while draining.
        soft_clear();
        auto_sts = 1'b1; m_axis_cmd_tready = 1'b1; continuous = 1'b1;
        start_run(32'h4000_0000, 32'h2000);
        found = 1'b0; done_seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (done) done_seen = 1'b1;
            if (run_cycles == 8'd2) begin
                found = 1'b1;
                break;
            end
        end
        chk("t5_two_passes", {71'd0, found}, 72'd1);
        chk("t5_no_done", {71'd0, done_seen}, 72'd0);
        chk("t5_ncmd_ge4", {71'd0, (cmd_q.size() >= 4)}, 72'd1);
        chk("t5_cmd1", cmd_q[1], mk(4'd1, 32'h4000_1000, 23'h1000));
        chk("t5_cmd2_wrap", cmd_q[2], mk(4'd2, 32'h4000_0000, 23'h1000));
        chk("t5_cmd3", cmd_q[3], mk(4'd3, 32'h4000_1000, 23'h1000));
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (busy && !m_axis_cmd_tvalid) begin
                found = 1'b1;
                break;
            end
        end
        chk("t5_drain_seen", {71'd0, found}, 72'd1);
        write_reset = 1'b1;
        tick();
        write_reset = 1'b0;
        chk("t5_reset_drain", {70'd0, busy, m_axis_cmd_tvalid}, 72'd0);
        chk("t5_runs_clr", {64'd0, run_cycles}, 72'd0);

        // Status tag mismatch.
        soft_clear();
        m_axis_cmd_tready = 1'b1;
        start_run(32'h6000_0000, 32'h1000);
        repeat (3) tick();
        chk("t6_ncmd", cmd_q.size(), 1);
        sts_fifo.push_back(8'h85);
        repeat (2) tick();
`ifdef S2MM_TAG_CHECK_EN
        chk("t6_tag_err", {70'd0, busy, wr_err}, 72'h3);
`else
        chk("t6_tag_ignored", {70'd0, busy, wr_err}, 72'h0);
        chk("t6_runs", {64'd0, run_cycles}, 72'd1);
`endif

        // Asynchronous reset drops tvalid immediately.
        soft_clear();
        start_run(32'h7000_0000, 32'h1000);
        chk("t7_tvalid_pre", {71'd0, m_axis_cmd_tvalid}, 72'd1);
        rst = 1'b1;
        #1;
        chk("t7_async_rst", {70'd0, busy, m_axis_cmd_tvalid}, 72'd0);
        tick();
        rst = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/axis_cmd_gen_s2mm.md
# axis_cmd_gen_s2mm

Command generator for the AXI DataMover S2MM (stream-to-memory) channel. It is the write-direction counterpart of the MM2S read command path. On a start request it splits a capture region (base address plus byte count) into PACKET_SIZE-byte write commands and issues them on the DataMover command stream. It consumes the returned status words, tracks outstanding commands, and reports progress, completion and errors to the register block.

## Interface
Parameters:
- PACKET_SIZE, 4096: bytes per command (BTT). Power of two, at most 2^23-1.
- MAX_OUTSTANDING, 4: maximum commands issued without a returned status (1..15).

Ports:
- clk  in  1  command/status clock; all logic is on this clock.
- rst  in  1  reset, asynchronous, active-high.
- write_start  in  1  single-cycle start request.
- write_reset  in  1  synchronous soft clear; returns the block to idle.
- continuous  in  1  1 = loop over the region until write_reset.
- base_addr  in  32  start byte address.
- cap_size  in  32  region size in bytes.
- m_axis_cmd_tdata  out  72  DataMover command.
- m_axis_cmd_tvalid  out  1  command valid.
- m_axis_cmd_tready  in  1  command accepted.
- s_axis_sts_tdata  in  8  DataMover status: [7] OKAY, [6] SLVERR, [5] DECERR, [4] INTERR, [3:0] tag.
- s_axis_sts_tvalid  in  1  status valid.
- s_axis_sts_tready  out  1  tied to 1.
- busy  out  1  high when the state is not IDLE.
- done  out  1  one-cycle pulse when a non-continuous run completes.
- wr_err  out  1  sticky error flag.
- current_addr  out  32  address of the last accepted command.
- run_cycles  out  8  count of completed region passes; wraps at 255.
- datamover_status  out  8  last received status word.

## Operation
- Command fields:
  - [71:68] = 0
  - [67:64] = tag
  - [63:32] = address
  - [31] DRR = 0
  - [30] EOF = 1
  - [29:24] DSA = 0
  - [23] type = 1 (INCR)
  - [22:0] BTT = min(remaining, PACKET_SIZE)
- The tag starts at 0 and increments modulo 16 on every accepted command.
- IDLE:
  - write_start with cap_size != 0: latch base_addr and cap_size; set addr = base; set remaining = cap_size; go to ISSUE.
  - write_start with cap_size == 0: ignored.
  - write_start while busy: ignored.
- ISSUE:
  - Present a command only while outstanding < MAX_OUTSTANDING and wr_err == 0.
  - On handshake: addr += BTT; remaining -= BTT (32-bit arithmetic); outstanding += 1; current_addr <= command address.
  - When the command with remaining == BTT is accepted, go to DRAIN.
  - A non-multiple cap_size gives a short final BTT.
- DRAIN: wait for outstanding == 0, then increment run_cycles.
  - If continuous == 1 and wr_err == 0: reload addr and remaining from the latched values and go to ISSUE.
  - Otherwise pulse done and go to IDLE.
- Status handling:
  - Every status handshake decrements outstanding and updates datamover_status.
  - A command handshake and a status handshake in the same cycle leave outstanding unchanged.
  - A status arriving when outstanding == 0 is dropped; the counter does not underflow.
  - Status with OKAY == 0, or any of bits [6:4] set, sets wr_err.
- ERROR:
  - Entered from ISSUE or DRAIN when wr_err is set and no command is pending.
  - A pending command (tvalid already high) is held until its handshake, then the block enters ERROR.
  - ERROR issues nothing and keeps accepting status.
  - It leaves only on write_reset.
- write_reset, in any state:
  - Next cycle: IDLE, tvalid = 0, outstanding = 0, tag = 0, wr_err = 0, run_cycles = 0, current_addr = 0, datamover_status = 0.
  - write_reset has priority over write_start in the same cycle.

## Timing
- Reset values: all outputs 0, except s_axis_sts_tready = 1.
- The first command's tvalid asserts 1 cycle after write_start is sampled.
- Commands issue back-to-back, one per cycle, while tready == 1 and the outstanding limit allows.
- tvalid and tdata are registered and stay stable until the handshake; tvalid never drops without a handshake, except on rst or write_reset.
- done asserts 1 cycle after the final status is received; it is never asserted in continuous mode.
- wr_err asserts 1 cycle after the offending status is received.
- rst asserted mid-run clears everything immediately; tvalid drops asynchronously.

## Configuration
- S2MM_TAG_CHECK_EN defined:
  - The block keeps a 4-bit expected-tag counter, incremented per status.
  - A status whose tag differs from the expected tag sets wr_err.
- Undefined: the tag field of the status is ignored.

## Structure
- Shared package axis_dm_pkg holds:
  - Command field bit positions and status bit positions.
  - State enum (IDLE, ISSUE, DRAIN, ERROR).
  - A command-packing function.
- No sub-module; a single module with the FSM and counters.

## Test plan
- base=0x1000_0000, cap=0x3000, tready=1, immediate OKAY status (0x80|tag) -> 3 commands:
  - Addresses 0x1000_0000, 0x1000_1000, 0x1000_2000; BTT 0x1000 each; tags 0,1,2.
  - done pulse; run_cycles = 1.
- cap=0x2100 -> 3 commands; the last has BTT 0x100 at base+0x2000.
- MAX_OUTSTANDING=4, no status returned, cap=0x8000 -> exactly 4 commands accepted and tvalid low. Returning one status releases the 5th command.
- Status 0x41 (SLVERR) after the first command -> wr_err = 1 the next cycle; no further commands after any pending one. write_reset clears wr_err and sets busy = 0.
- continuous = 1, cap=0x2000, OKAY status -> address sequence wraps to base after 2 commands; run_cycles increments per pass. write_reset mid-DRAIN -> busy = 0 and tvalid = 0 the next cycle.
- With S2MM_TAG_CHECK_EN, status tag 5 when 0 is expected -> wr_err = 1.
